mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of address buses.
REQ-002 Parameter: DATA_W, default 32, width of data buses.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1  access request, requester 0 (processor data port) / requester 1 (loader).
REQ-006 we0/we1  input  1  write enable of the request; 0 = read.
REQ-007 addr0/addr1  input  ADDR_W  word address of the request.
REQ-008 wdata0/wdata1  input  DATA_W  write data.
REQ-009 lock0/lock1  input  1  hold ownership for the next access (ARB_LOCK_EN only; ignored otherwise).
REQ-010 gnt0/gnt1  output  1  access accepted this cycle.
REQ-011 rvalid0/rvalid1  output  1  read data valid for the requester.
REQ-012 rdata  output  DATA_W  read data, common to both requesters.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid one cycle after the address is presented.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-018 gnt is combinational from req in the same cycle; a request is accepted on a clock edge where its gnt is high.
REQ-019 Single requester active: its gnt SHALL be high.
REQ-020 Both requesters active and no lock held: the requester not granted most recently SHALL win (round-robin). The last-granted register updates only on a granted cycle.
REQ-021 mem_addr/mem_wdata SHALL carry the granted requester's addr/wdata; with no grant they carry requester 0's values.
REQ-022 mem_we SHALL equal (gnt0 & we0) | (gnt1 & we1); it is never high without a grant.
REQ-023 A granted read SHALL raise the matching rvalid for exactly one cycle, one cycle after the grant; rdata = mem_rdata in that cycle.
REQ-024 Back-to-back reads from alternating requesters SHALL give one rvalid per cycle, in grant order, with no bubble.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 A request dropped before it is granted SHALL have no effect on memory or on the last-granted register.

Reset
REQ-027 While reset is low: gnt0=gnt1=0, mem_we=0, rvalid0=rvalid1=0, lock owner cleared, last-granted = requester 1 (requester 0 wins the first conflict).
REQ-028 A reset asserted while a read is outstanding SHALL drop that read; no rvalid appears after reset is released.
REQ-029 Normal arbitration resumes on the first posedge after reset goes high.

Configuration
REQ-030 With macro ARB_LOCK_EN defined: a grant with lockN=1 makes requester N the owner; the owner is granted on every cycle it requests, regardless of round-robin; ownership is released by a granted access with lockN=0 or by a cycle with reqN=0.
REQ-031 With ARB_LOCK_EN undefined: lock0/lock1 are ignored and no owner state exists; arbitration is pure round-robin.

Verification
REQ-032 Reset release, req0=req1=1 both reads, addr0=0x10, addr1=0x20 -> cycle0 gnt0, mem_addr=0x10; cycle1 gnt1, rvalid0 with mem_rdata of 0x10; cycle2 rvalid1.
REQ-033 req1 alone writes 0xDEADBEEF to 0x40 -> gnt1=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, no rvalid.
REQ-034 Both request for 6 cycles -> grants alternate 0,1,0,1,0,1; never both high.
REQ-035 ARB_LOCK_EN, req1 with lock1=1 for 3 accesses and req0 held high -> gnt1 on 3 consecutive cycles, then gnt0 once lock1=0 is granted.
REQ-036 Read granted, reset low on the next cycle -> rvalid stays 0, and no rvalid after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
// Optional owner locking is compiled in with ARB_LOCK_EN.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic last1;
  logic g0;
  logic g1;
  logic rv0_q;
  logic rv1_q;

`ifdef ARB_LOCK_EN
  logic own_vld;
  logic own;
  logic own_req;

  assign own_req = own ? req1 : req0;
`else
  logic unused_lock;

  assign unused_lock = lock0 | lock1;
`endif

  // grant select: owner first, then round-robin on conflict
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
`ifdef ARB_LOCK_EN
    else if (own_vld && own_req) begin
      g0 = ~own;
      g1 = own;
    end
`endif
    else if (req0 && req1) begin
      g0 = last1;
      g1 = ~last1;
    end else begin
      g0 = req0;
      g1 = req1;
    end
  end

  // last-granted history, moves only on a grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last1 <= 1'b1;
    end else if (g0) begin
      last1 <= 1'b0;
    end else if (g1) begin
      last1 <= 1'b1;
    end
  end

  // read return strobe, one cycle behind the grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= g0 & ~we0;
      rv1_q <= g1 & ~we1;
    end
  end

`ifdef ARB_LOCK_EN
  // lock owner tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_vld <= 1'b0;
      own     <= 1'b0;
    end else if (g0) begin
      own_vld <= lock0;
      own     <= 1'b0;
    end else if (g1) begin
      own_vld <= lock1;
      own     <= 1'b1;
    end else if (!own_req) begin
      own_vld <= 1'b0;
    end
  end
`endif

  assign gnt0      = g0;
  assign gnt1      = g1;
  assign rvalid0   = rv0_q;
  assign rvalid1   = rv1_q;
  assign rdata     = mem_rdata;
  assign mem_we    = (g0 & we0) | (g1 & we1);
  assign mem_addr  = g1 ? addr1 : addr0;
  assign mem_wdata = g1 ? wdata1 : wdata0;

endmodule
